// File: rtl/scamp_pkg.sv
// Shared definitions for the SCAMP sequencer: flag bit positions, default
// vectors and the T-state counter width helper.
package scamp_pkg;

    localparam int unsigned FLAG_C  = 2;
    localparam int unsigned FLAG_Z  = 1;
    localparam int unsigned FLAG_LT = 0;

    localparam int unsigned DEF_WIDTH        = 16;
    localparam int unsigned DEF_TSTATES      = 8;
    localparam int unsigned DEF_RESET_VECTOR = 0;
    localparam int unsigned DEF_IRQ_VECTOR   = 2;

    // Width of the T-state counter; TSTATES is always at least 2.
    function automatic int unsigned tw(input int unsigned tstates);
        return (tstates <= 2) ? 1 : $clog2(tstates);
    endfunction

endpackage

// File: rtl/microseq_tstate.sv
// T-state counter: wraps on rt or after the last T-state and holds while
// the bus is stalled.
module microseq_tstate
    import scamp_pkg::*;
#(
    parameter int unsigned TSTATES = DEF_TSTATES
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       stall_i,
    input  logic                       rt_i,
    output logic [tw(TSTATES)-1:0]     t_o,
    output logic                       boundary_o
);

    localparam int unsigned TW = tw(TSTATES);

    logic [TW-1:0] t_q;
    logic [TW-1:0] t_d;

    assign boundary_o = rt_i | (t_q == TW'(TSTATES - 1));
    assign t_o        = t_q;

    always_comb begin
        t_d = t_q;
        if (!stall_i) begin
            t_d = boundary_o ? '0 : t_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            t_q <= '0;
        end else begin
            t_q <= t_d;
        end
    end

endmodule

// File: rtl/microseq.sv
// SCAMP instruction sequencer: PC, IR, latched ALU flags, conditional jumps,
// memory wait-state stalling and a single-level maskable interrupt.
module microseq
    import scamp_pkg::*;
#(
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned TSTATES      = DEF_TSTATES,
    parameter int unsigned RESET_VECTOR = DEF_RESET_VECTOR,
    parameter int unsigned IRQ_VECTOR   = DEF_IRQ_VECTOR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       bus_in,
    input  logic                   ii,
    input  logic                   pp,
    input  logic                   rt,
    input  logic                   eo,
    input  logic                   c_in,
    input  logic                   z_in,
    input  logic                   lt_in,
    input  logic                   jc,
    input  logic                   jz,
    input  logic                   jnz,
    input  logic                   jgt,
    input  logic                   jlt,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    input  logic                   irq,
    input  logic                   ei,
    input  logic                   di,
    input  logic                   iret,
    output logic [tw(TSTATES)-1:0] t,
    output logic [WIDTH-1:0]       pc,
    output logic [WIDTH-1:0]       ir,
    output logic [2:0]             flags,
    output logic                   jmp,
    output logic                   stall,
    output logic                   irq_ack,
    output logic                   irq_en
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] saved_pc_q, saved_pc_d;
    logic [2:0]       flags_q, flags_d;
    logic             irq_en_q, irq_en_d;
    logic             irq_ack_q, irq_ack_d;
    logic [WIDTH-1:0] pc_next;
    logic             boundary;
    logic             irq_entry;

    microseq_tstate #(
        .TSTATES (TSTATES)
    ) u_tstate (
        .clk_i      (clk),
        .reset_i    (reset),
        .stall_i    (stall),
        .rt_i       (rt),
        .t_o        (t),
        .boundary_o (boundary)
    );

    assign stall = mem_req & ~mem_ready;
    assign jmp   = (jc  &  flags_q[FLAG_C])
                 | (jz  &  flags_q[FLAG_Z])
                 | (jnz & ~flags_q[FLAG_Z])
                 | (jlt &  flags_q[FLAG_LT])
                 | (jgt & ~flags_q[FLAG_Z] & ~flags_q[FLAG_LT]);

    // pc_next is where PC would go without an interrupt; entry saves it so
    // the interrupted jump or increment is resumed on iret.
    always_comb begin
        if (iret)     pc_next = saved_pc_q;
        else if (jmp) pc_next = bus_in;
        else if (pp)  pc_next = pc_q + WIDTH'(1);
        else          pc_next = pc_q;
    end

    assign irq_entry = ~stall & boundary & irq & irq_en_q & ~iret;

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        flags_d    = flags_q;
        saved_pc_d = saved_pc_q;
        irq_en_d   = irq_en_q;
        irq_ack_d  = irq_entry;
        if (!stall) begin
            if (ii) ir_d = bus_in;
            if (eo) begin
                flags_d[FLAG_C]  = c_in;
                flags_d[FLAG_Z]  = z_in;
                flags_d[FLAG_LT] = lt_in;
            end
            if (irq_entry) begin
                pc_d       = WIDTH'(IRQ_VECTOR);
                saved_pc_d = pc_next;
                irq_en_d   = 1'b0;
            end else begin
                pc_d = pc_next;
                if (ei || iret) irq_en_d = 1'b1;
                if (di)         irq_en_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= WIDTH'(RESET_VECTOR);
            ir_q       <= '0;
            flags_q    <= '0;
            saved_pc_q <= '0;
            irq_en_q   <= 1'b0;
            irq_ack_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            flags_q    <= flags_d;
            saved_pc_q <= saved_pc_d;
            irq_en_q   <= irq_en_d;
            irq_ack_q  <= irq_ack_d;
        end
    end

    assign pc      = pc_q;
    assign ir      = ir_q;
    assign flags   = flags_q;
    assign irq_en  = irq_en_q;
    assign irq_ack = irq_ack_q;

endmodule

// File: tb/tb_microseq.sv
// Self-checking bench for microseq: directed scenarios followed by random
// control traffic, all compared against a cycle-level reference model.
module tb_microseq;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned TSTATES = 8;
    localparam int unsigned RSTV    = 0;
    localparam int unsigned IRQV    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_in;
    logic        ii, pp, rt, eo, c_in, z_in, lt_in;
    logic        jc, jz, jnz, jgt, jlt;
    logic        mem_req, mem_ready, irq, ei, di, iret;
    logic [2:0]  t;
    logic [15:0] pc, ir;
    logic [2:0]  flags;
    logic        jmp, stall, irq_ack, irq_en;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model state
    int unsigned m_t, m_pc, m_ir, m_saved;
    bit          m_c, m_z, m_lt, m_en, m_ack;

    microseq #(
        .WIDTH        (WIDTH),
        .TSTATES      (TSTATES),
        .RESET_VECTOR (RSTV),
        .IRQ_VECTOR   (IRQV)
    ) dut (
        .clk(clk), .reset(reset), .bus_in(bus_in), .ii(ii), .pp(pp), .rt(rt),
        .eo(eo), .c_in(c_in), .z_in(z_in), .lt_in(lt_in), .jc(jc), .jz(jz),
        .jnz(jnz), .jgt(jgt), .jlt(jlt), .mem_req(mem_req),
        .mem_ready(mem_ready), .irq(irq), .ei(ei), .di(di), .iret(iret),
        .t(t), .pc(pc), .ir(ir), .flags(flags), .jmp(jmp), .stall(stall),
        .irq_ack(irq_ack), .irq_en(irq_en)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        reset = 0; bus_in = '0; ii = 0; pp = 0; rt = 0; eo = 0;
        c_in = 0; z_in = 0; lt_in = 0; jc = 0; jz = 0; jnz = 0; jgt = 0; jlt = 0;
        mem_req = 0; mem_ready = 1; irq = 0; ei = 0; di = 0; iret = 0;
    endtask

    function automatic bit model_jmp();
        return (jc && m_c) || (jz && m_z) || (jnz && !m_z) || (jlt && m_lt) ||
               (jgt && !m_z && !m_lt);
    endfunction

    function automatic bit model_stall();
        return mem_req && !mem_ready;
    endfunction

    // Apply the current inputs for one clock and check everything.
    task automatic step();
        bit          j, s, bnd, entry;
        int unsigned target;
        #1;
        j = model_jmp();
        s = model_stall();
        check_eq("jmp", jmp, j);
        check_eq("stall", stall, s);
        if (reset) begin
            m_t = 0; m_pc = RSTV; m_ir = 0; m_saved = 0;
            m_c = 0; m_z = 0; m_lt = 0; m_en = 0; m_ack = 0;
        end else if (s) begin
            m_ack = 0;
        end else begin
            bnd = rt || (m_t == TSTATES - 1);
            entry = bnd && irq && m_en && !iret;
            if (iret)    target = m_saved;
            else if (j)  target = bus_in;
            else if (pp) target = (m_pc + 1) % 65536;
            else         target = m_pc;
            m_t = bnd ? 0 : m_t + 1;
            if (ii) m_ir = bus_in;
            if (eo) begin m_c = c_in; m_z = z_in; m_lt = lt_in; end
            m_ack = entry;
            if (entry) begin
                m_saved = target; m_pc = IRQV; m_en = 0;
            end else begin
                m_pc = target;
                if (di) m_en = 0;
                else if (ei || iret) m_en = 1;
            end
        end
        @(posedge clk);
        #1;
        check_eq("t", t, m_t);
        check_eq("pc", pc, m_pc);
        check_eq("ir", ir, m_ir);
        check_eq("flags", flags, {m_c, m_z, m_lt});
        check_eq("irq_en", irq_en, m_en);
        check_eq("irq_ack", irq_ack, m_ack);
    endtask

    initial begin
        m_t = 0; m_pc = 0; m_ir = 0; m_saved = 0;
        m_c = 0; m_z = 0; m_lt = 0; m_en = 0; m_ack = 0;
        idle();
        reset = 1;
        @(negedge clk);
        step(); step();

        // Free-run wrap, then rt at t=3
        idle();
        repeat (10) step();
        while (m_t != 3) step();
        rt = 1; step(); rt = 0;
        check_eq("rt_wrap_t", t, 0);

        // Jump to 0x0010 (flags clear so jnz is taken), then stall at t=2 with pp
        jnz = 1; bus_in = 16'h0010; step(); jnz = 0;
        while (m_t != 2) step();
        pp = 1; mem_req = 1; mem_ready = 0;
        repeat (3) step();
        check_eq("stall_hold_pc", pc, 16'h0010);
        mem_ready = 1; step();
        check_eq("stall_release_pc", pc, 16'h0011);
        check_eq("stall_release_t", t, 3);
        mem_req = 0; pp = 0;

        // Flag timing: eo with z_in=1 and jz; jump only next cycle
        eo = 1; z_in = 1; jz = 1; bus_in = 16'h1234; pp = 1; step();
        eo = 0; z_in = 0; step();
        check_eq("jz_taken_pc", pc, 16'h1234);
        jz = 0;

        // Wrap at all-ones: jump to FFFF via jc-less jz, then increment
        bus_in = 16'hFFFF; jz = 1; step(); jz = 0; step();
        check_eq("pc_wrap", pc, 16'h0000);
        pp = 0;

        // Interrupt entry at pc=0x0040 with rt+pp, then iret
        eo = 1; step(); eo = 0;
        jnz = 1; bus_in = 16'h0040; ei = 1; step(); jnz = 0; ei = 0;
        irq = 1; rt = 1; pp = 1; step();
        check_eq("irq_entry_pc", pc, IRQV);
        irq = 0; rt = 0; pp = 0; step();
        iret = 1; step(); iret = 0;
        check_eq("iret_pc", pc, 16'h0041);

        // Reset during stall at t=5 with interrupts enabled
        while (m_t != 5) step();
        mem_req = 1; mem_ready = 0; step();
        reset = 1; step(); reset = 0; mem_req = 0;
        check_eq("reset_t", t, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            idle();
            reset     = ($urandom_range(0, 199) == 0);
            bus_in    = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
            ii        = $urandom_range(0, 3) == 0;
            pp        = $urandom_range(0, 1) == 0;
            rt        = $urandom_range(0, 5) == 0;
            eo        = $urandom_range(0, 3) == 0;
            {c_in, z_in, lt_in} = 3'($urandom);
            jc        = $urandom_range(0, 7) == 0;
            jz        = $urandom_range(0, 7) == 0;
            jnz       = $urandom_range(0, 7) == 0;
            jgt       = $urandom_range(0, 7) == 0;
            jlt       = $urandom_range(0, 7) == 0;
            mem_req   = $urandom_range(0, 2) == 0;
            mem_ready = $urandom_range(0, 2) != 0;
            irq       = $urandom_range(0, 3) == 0;
            ei        = $urandom_range(0, 5) == 0;
            di        = $urandom_range(0, 11) == 0;
            iret      = $urandom_range(0, 19) == 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/microseq.md
Name: microseq

Overview:
- Parametrised instruction sequencer for the SCAMP core.
- Contains the T-state counter, PC, IR, latched ALU flags and conditional-jump evaluation.
- Adds three things the first-generation core lacks: configurable data width and T-state depth, memory wait-state stalling, and a single-level maskable interrupt with return.
- Sits between the microcode decoder, which drives its control inputs, and the bus/ALU datapath.

Parameters:
- WIDTH, 16, width of bus, PC and IR.
- TSTATES, 8, T-states per instruction before forced wrap; range 2..16.
- RESET_VECTOR, 0, PC value after reset.
- IRQ_VECTOR, 2, PC value loaded on interrupt entry.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- bus_in  in  WIDTH  current bus value (jump target / IR source).
- ii  in  1  load IR from bus_in.
- pp  in  1  increment PC.
- rt  in  1  end instruction; T returns to 0.
- eo  in  1  latch ALU flags (ALU driving bus).
- c_in, z_in, lt_in  in  1 each  ALU carry, zero and less-than.
- jc, jz, jnz, jgt, jlt  in  1 each  jump-condition selects.
- mem_req  in  1  current T-state performs a memory access.
- mem_ready  in  1  memory access completes this cycle.
- irq  in  1  level-sensitive interrupt request.
- ei, di, iret  in  1 each  enable interrupts, disable interrupts, return from interrupt.
- t  out  clog2(TSTATES)  current T-state.
- pc  out  WIDTH  program counter.
- ir  out  WIDTH  instruction register.
- flags  out  3  {C,Z,LT} latched.
- jmp  out  1  jump taken this cycle (combinational).
- stall  out  1  mem_req & !mem_ready (combinational).
- irq_ack  out  1  one-cycle pulse on interrupt entry.
- irq_en  out  1  interrupt enable state.

Behaviour:
- Reset (synchronous, wins over everything):
  - t=0, pc=RESET_VECTOR, ir=0, flags=0, irq_en=0, saved_pc=0, irq_ack=0.
  - Reset mid-stall or mid-interrupt discards all in-progress state.
- jmp = (jc&C)|(jz&Z)|(jnz&!Z)|(jlt&LT)|(jgt&!Z&!LT), using latched flags.
  - Flags latched in the same cycle are not visible until the next cycle.
- stall=1 freezes everything for that cycle:
  - t, pc, ir, flags, irq_en and saved_pc hold.
  - ii/pp/rt/eo/ei/di/iret are ignored; jmp still reflects its inputs.
- Non-stalled cycle:
  - T-state: boundary = rt | (t==TSTATES-1). At a boundary t←0, otherwise t←t+1.
  - IR: ii loads ir←bus_in.
  - Flags: eo loads flags←{c_in,z_in,lt_in}.
  - PC, first match wins:
    1. interrupt entry
    2. iret → saved_pc
    3. jmp → bus_in
    4. pp → pc+1, wrapping modulo 2^WIDTH (all-ones → 0)
    5. hold
- Interrupt entry condition: boundary & irq & irq_en & !iret.
  - saved_pc ← the value PC would have taken this cycle via rules 2-5 (jump/increment preserved).
  - pc ← IRQ_VECTOR, irq_en ← 0, irq_ack=1 on the next cycle only.
- iret (non-stalled): pc←saved_pc, irq_en←1.
- Enable/disable:
  - ei sets irq_en and di clears it.
  - ei and di together: di wins.
  - ei at a boundary does not allow entry in that same cycle; irq_en takes effect the following cycle.
- irq held high after entry does not re-enter until irq_en returns to 1. There is no nesting; saved_pc is single-depth.
- Latency:
  - All registered outputs update one cycle after the qualifying inputs.
  - jmp and stall are combinational with zero latency.

Decomposition:
- Shared package scamp_pkg holds:
  - flag bit indices (FLAG_C=2, FLAG_Z=1, FLAG_LT=0);
  - a function tw(TSTATES) returning the T-state width;
  - default vector constants.
- One natural sub-module: microseq_tstate, the T counter with boundary and stall inputs, t output and boundary output.
- PC, IR, flags and interrupt logic stay in microseq.

Test Plan:
- Free-run wrap: TSTATES=8, no rt, no stall, 10 cycles → t=0,1,…,7,0,1. With rt asserted at t=3 → next t=0.
- Stall: mem_req=1, mem_ready=0 for 3 cycles at t=2 with pp=1, pc=0x0010 → t=2 and pc=0x0010 held all 3 cycles. The cycle after mem_ready=1 → t=3, pc=0x0011.
- Jump priority: Z latched 1, jz=1, pp=1, bus_in=0x1234 → pc=0x1234, jmp=1. Same with Z=0 → pc=pc+1. pc=0xFFFF with pp → 0x0000.
- Flag timing: eo=1 with z_in=1 and jz=1 in the same cycle, old Z=0 → no jump that cycle; jump taken the next cycle if jz held.
- Interrupt: irq_en=1, irq=1, rt=1, pp=1, pc=0x0040 → pc=IRQ_VECTOR(0x0002), saved_pc=0x0041, irq_ack pulse, irq_en=0. Later iret → pc=0x0041, irq_en=1.
- Reset mid-operation: reset during stall at t=5 with irq_en=1 → next cycle t=0, pc=0, flags=0, irq_en=0, irq_ack=0.
